pc_src_unit: RTL and testbench
==============================

Name: pc_src_unit

Overview:
- Parametrised, registered successor to the two-input PC source mux.
- Owns the architectural fetch PC:
  - sequential increment;
  - N-way redirect selection;
  - stall hold;
  - buffering of a redirect that arrives during a stall;
  - misaligned-target trapping.
- Sits at the head of the fetch stage. It drives the instruction-memory address and takes redirect targets from branch, jump, trap and return logic.

Parameters:
- XLEN, 32, PC and target width.
- NUM_SRC, 4, number of redirect target inputs (2..8).
- SEL_W, 2, width of redirect select. Must be at least clog2(NUM_SRC).
- STEP, 4, sequential PC increment.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- TRAP_PC, 32'h0000_0100, PC loaded when a misalignment fault is cleared.
- ALIGN_BITS, 2, number of low target bits that must be zero.

Ports:
- clk_i, input, 1, clock. All state updates on the rising edge.
- rst_i, input, 1, synchronous active-high reset.
- stall_i, input, 1, hold PC (pipeline stall).
- redirect_valid_i, input, 1, redirect request this cycle.
- redirect_sel_i, input, SEL_W, index of the redirect target.
- redirect_targets_i, input, NUM_SRC*XLEN, packed targets. Target k occupies bits [k*XLEN +: XLEN].
- fault_clr_i, input, 1, acknowledge the fault and resume at TRAP_PC.
- pc_o, output, XLEN, current fetch PC.
- pc_valid_o, output, 1, pc_o is a valid fetch address.
- redirect_pending_o, output, 1, a buffered redirect is waiting for the stall to release.
- sel_err_o, output, 1, one-cycle pulse: redirect_sel_i >= NUM_SRC.
- misalign_o, output, 1, sticky fault flag.
- misalign_addr_o, output, XLEN, offending target.

Behaviour:
- Clock and reset: single clock clk_i; reset rst_i is synchronous and active-high.
  - rst_i has priority over every other input.
  - Reset values: pc_o=RESET_PC, pc_valid_o=0, redirect_pending_o=0, sel_err_o=0, misalign_o=0, misalign_addr_o=0.
  - Reset clears the pending buffer and the fault.
  - State goes to BOOT.
- States: BOOT, RUN, PEND, FAULT. All outputs are registered.
- Accepted redirect: redirect_valid_i=1 and redirect_sel_i<NUM_SRC.
  - Misaligned: target[ALIGN_BITS-1:0] != 0.
  - Aligned: not misaligned.
- Invalid select: redirect_valid_i=1 with redirect_sel_i>=NUM_SRC.
  - The request is ignored and no state changes.
  - sel_err_o=1 for the following cycle only.
  - Evaluated in RUN and PEND.
- BOOT: pc_valid_o=0. Next cycle goes to RUN with pc_o=RESET_PC and pc_valid_o=1. Inputs are ignored in BOOT.
- RUN, in priority order:
  1. Misaligned accepted redirect, regardless of stall_i:
     - go to FAULT;
     - misalign_o=1, misalign_addr_o=target;
     - pc_valid_o=0, pc_o held.
  2. Aligned accepted redirect with stall_i=0: pc_o <= target next edge (latency 1).
  3. Aligned accepted redirect with stall_i=1: capture target into the pending register, redirect_pending_o=1, pc_o held, go to PEND.
  4. No redirect, stall_i=0: pc_o <= pc_o + STEP, modulo 2^XLEN (wrap, no flag).
  5. No redirect, stall_i=1: pc_o held.
- PEND:
  - A new aligned accepted redirect overwrites the pending target (latest wins).
  - A misaligned one goes to FAULT and discards pending.
  - When stall_i=0:
    - pc_o <= new redirect target if present this cycle, else the pending target;
    - redirect_pending_o=0;
    - go to RUN.
  - The pending target is never combined with a STEP increment.
- FAULT:
  - pc_o held, pc_valid_o=0.
  - Redirects and stall_i are ignored.
  - fault_clr_i=1: pc_o <= TRAP_PC, misalign_o=0, pc_valid_o=1, go to RUN. misalign_addr_o retains its value.
- Reset mid-operation (any state): returns to BOOT next edge. Pending target and fault are lost.
- pc_o only changes on a clock edge. No combinational path from inputs to outputs.

Test Plan:
All scenarios use defaults.
1. Reset then release; stall_i=0, no redirects, 4 cycles:
   - BOOT cycle: pc_o=0x0, pc_valid_o=0;
   - then 0x0(valid), 0x4, 0x8, 0xC.
2. At pc_o=0x10, redirect_valid_i=1, sel=2, target2=0x200, stall_i=0 -> next pc_o=0x200, then 0x204.
3. Redirect stall buffering:
   - stall_i=1 at pc_o=0x20; redirect sel=1 target1=0x80 -> redirect_pending_o=1, pc_o stays 0x20;
   - next cycle redirect sel=3 target3=0xC0 while stalled -> overwrite;
   - release stall -> pc_o=0xC0, redirect_pending_o=0.
4. Misaligned target:
   - redirect sel=0 target0=0x102 -> misalign_o=1, misalign_addr_o=0x102, pc_valid_o=0, pc_o held;
   - further redirects ignored;
   - fault_clr_i=1 -> pc_o=0x100, pc_valid_o=1, misalign_o=0.
5. Wrap and invalid select (NUM_SRC=3, SEL_W=2 instance):
   - pc_o=0xFFFF_FFFC -> next 0x0;
   - redirect sel=3 -> sel_err_o one-cycle pulse, PC increments normally.
6. Reset mid-PEND:
   - with redirect_pending_o=1, assert rst_i with stall_i=1 and a redirect present -> next edge pc_o=0x0, pc_valid_o=0, redirect_pending_o=0;
   - buffered target never appears.

Source files
------------

// File: rtl/pc_src_unit.sv
// Registered fetch-PC source: sequential step, N-way redirect, stall hold,
// stall-time redirect buffering and misaligned-target fault handling.
module pc_src_unit #(
    parameter int              XLEN       = 32,
    parameter int              NUM_SRC    = 4,
    parameter int              SEL_W      = 2,
    parameter int              STEP       = 4,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] TRAP_PC    = 32'h0000_0100,
    parameter int              ALIGN_BITS = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    stall_i,
    input  logic                    redirect_valid_i,
    input  logic [SEL_W-1:0]        redirect_sel_i,
    input  logic [NUM_SRC*XLEN-1:0] redirect_targets_i,
    input  logic                    fault_clr_i,
    output logic [XLEN-1:0]         pc_o,
    output logic                    pc_valid_o,
    output logic                    redirect_pending_o,
    output logic                    sel_err_o,
    output logic                    misalign_o,
    output logic [XLEN-1:0]         misalign_addr_o
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PEND  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic [XLEN-1:0]   pc_r, pc_nxt_s;
    logic              pc_valid_r, pc_valid_nxt_s;
    logic              pend_r, pend_nxt_s;
    logic [XLEN-1:0]   pend_tgt_r, pend_tgt_nxt_s;
    logic              sel_err_r, sel_err_nxt_s;
    logic              misalign_r, misalign_nxt_s;
    logic [XLEN-1:0]   maddr_r, maddr_nxt_s;

    logic [XLEN-1:0]   tgt_s;
    logic              sel_ok_s;
    logic              bad_sel_s;
    logic              mis_s;
    logic              aligned_s;

    function automatic logic is_misaligned(input logic [XLEN-1:0] addr);
        return (addr[ALIGN_BITS-1:0] != {ALIGN_BITS{1'b0}});
    endfunction

    // Select the addressed redirect target and classify the request.
    always_comb begin
        tgt_s = {XLEN{1'b0}};
        for (int k = 0; k < NUM_SRC; k++) begin
            tgt_s = (redirect_sel_i == SEL_W'(k)) ? redirect_targets_i[k*XLEN +: XLEN] : tgt_s;
        end
        sel_ok_s  = (32'(redirect_sel_i) < 32'(NUM_SRC));
        bad_sel_s = redirect_valid_i & ~sel_ok_s;
        mis_s     = redirect_valid_i & sel_ok_s & is_misaligned(tgt_s);
        aligned_s = redirect_valid_i & sel_ok_s & ~is_misaligned(tgt_s);
    end

    // Next-state and next-output computation for the PC sequencer.
    always_comb begin
        state_nxt_s    = state_r;
        pc_nxt_s       = pc_r;
        pc_valid_nxt_s = pc_valid_r;
        pend_nxt_s     = pend_r;
        pend_tgt_nxt_s = pend_tgt_r;
        sel_err_nxt_s  = 1'b0;
        misalign_nxt_s = misalign_r;
        maddr_nxt_s    = maddr_r;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s    = ST_RUN;
                pc_nxt_s       = RESET_PC;
                pc_valid_nxt_s = 1'b1;
            end
            ST_RUN: begin
                sel_err_nxt_s = bad_sel_s;
                if (mis_s) begin
                    state_nxt_s    = ST_FAULT;
                    misalign_nxt_s = 1'b1;
                    maddr_nxt_s    = tgt_s;
                    pc_valid_nxt_s = 1'b0;
                end else if (aligned_s && !stall_i) begin
                    pc_nxt_s = tgt_s;
                end else if (aligned_s) begin
                    pend_tgt_nxt_s = tgt_s;
                    pend_nxt_s     = 1'b1;
                    state_nxt_s    = ST_PEND;
                end else if (!stall_i) begin
                    pc_nxt_s = pc_r + XLEN'(STEP);
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_PEND: begin
                sel_err_nxt_s = bad_sel_s;
                if (mis_s) begin
                    state_nxt_s    = ST_FAULT;
                    misalign_nxt_s = 1'b1;
                    maddr_nxt_s    = tgt_s;
                    pc_valid_nxt_s = 1'b0;
                    pend_nxt_s     = 1'b0;
                end else if (!stall_i) begin
                    // Latest redirect wins over the buffered one; never stepped.
                    pc_nxt_s    = aligned_s ? tgt_s : pend_tgt_r;
                    pend_nxt_s  = 1'b0;
                    state_nxt_s = ST_RUN;
                end else if (aligned_s) begin
                    pend_tgt_nxt_s = tgt_s;
                end else begin
                    pend_tgt_nxt_s = pend_tgt_r;
                end
            end
            ST_FAULT: begin
                if (fault_clr_i) begin
                    pc_nxt_s       = TRAP_PC;
                    misalign_nxt_s = 1'b0;
                    pc_valid_nxt_s = 1'b1;
                    state_nxt_s    = ST_RUN;
                end else begin
                    state_nxt_s = ST_FAULT;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r    <= ST_BOOT;
            pc_r       <= RESET_PC;
            pc_valid_r <= 1'b0;
            pend_r     <= 1'b0;
            pend_tgt_r <= {XLEN{1'b0}};
            sel_err_r  <= 1'b0;
            misalign_r <= 1'b0;
            maddr_r    <= {XLEN{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            pc_r       <= pc_nxt_s;
            pc_valid_r <= pc_valid_nxt_s;
            pend_r     <= pend_nxt_s;
            pend_tgt_r <= pend_tgt_nxt_s;
            sel_err_r  <= sel_err_nxt_s;
            misalign_r <= misalign_nxt_s;
            maddr_r    <= maddr_nxt_s;
        end
    end

    assign pc_o               = pc_r;
    assign pc_valid_o         = pc_valid_r;
    assign redirect_pending_o = pend_r;
    assign sel_err_o          = sel_err_r;
    assign misalign_o         = misalign_r;
    assign misalign_addr_o    = maddr_r;

endmodule

// File: tb/tb_pc_src_unit.sv
// Scoreboard bench for pc_src_unit: default instance plus a NUM_SRC=3 instance.
module tb_pc_src_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic        v;
        logic        pend;
        logic        serr;
        logic        mis;
        logic [31:0] maddr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_a = 1'b1, rst_b = 1'b1;
    logic        stall = 1'b0, rv = 1'b0, clr = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] tg [4];
    logic [127:0] targets;

    logic [31:0] pc_a, maddr_a, pc_b, maddr_b;
    logic        v_a, pend_a, serr_a, mis_a, v_b, pend_b, serr_b, mis_b;

    exp_t qa[$];
    exp_t qb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign targets = {tg[3], tg[2], tg[1], tg[0]};

    pc_src_unit dut_a (
        .clk_i(clk), .rst_i(rst_a), .stall_i(stall), .redirect_valid_i(rv),
        .redirect_sel_i(sel), .redirect_targets_i(targets), .fault_clr_i(clr),
        .pc_o(pc_a), .pc_valid_o(v_a), .redirect_pending_o(pend_a),
        .sel_err_o(serr_a), .misalign_o(mis_a), .misalign_addr_o(maddr_a)
    );

    pc_src_unit #(.NUM_SRC(3), .SEL_W(2)) dut_b (
        .clk_i(clk), .rst_i(rst_b), .stall_i(stall), .redirect_valid_i(rv),
        .redirect_sel_i(sel), .redirect_targets_i(targets[95:0]), .fault_clr_i(clr),
        .pc_o(pc_b), .pc_valid_o(v_b), .redirect_pending_o(pend_b),
        .sel_err_o(serr_b), .misalign_o(mis_b), .misalign_addr_o(maddr_b)
    );

    // Monitor: after each edge, pop the expected response and compare.
    always @(posedge clk) begin
        exp_t act, e;
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            act = '{pc_a, v_a, pend_a, serr_a, mis_a, maddr_a};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL dut_a: got pc=%h v=%b pend=%b serr=%b mis=%b maddr=%h, want pc=%h v=%b pend=%b serr=%b mis=%b maddr=%h",
                         act.pc, act.v, act.pend, act.serr, act.mis, act.maddr,
                         e.pc, e.v, e.pend, e.serr, e.mis, e.maddr);
            end
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            act = '{pc_b, v_b, pend_b, serr_b, mis_b, maddr_b};
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL dut_b: got pc=%h v=%b pend=%b serr=%b mis=%b maddr=%h, want pc=%h v=%b pend=%b serr=%b mis=%b maddr=%h",
                         act.pc, act.v, act.pend, act.serr, act.mis, act.maddr,
                         e.pc, e.v, e.pend, e.serr, e.mis, e.maddr);
            end
        end
    end

    task automatic step(input bit which_b, input logic r, input logic st, input logic req,
                        input logic [1:0] s, input logic [31:0] t, input logic c,
                        input logic [31:0] e_pc, input logic e_v, input logic e_pend,
                        input logic e_serr, input logic e_mis, input logic [31:0] e_maddr);
        exp_t e;
        @(negedge clk);
        if (which_b) rst_b = r; else rst_a = r;
        stall = st; rv = req; sel = s; clr = c;
        tg[0] = 32'h0; tg[1] = 32'h0; tg[2] = 32'h0; tg[3] = 32'h0;
        tg[s] = t;
        e = '{e_pc, e_v, e_pend, e_serr, e_mis, e_maddr};
        if (which_b) qb.push_back(e); else qa.push_back(e);
    endtask

    initial begin
        tg[0] = 32'h0; tg[1] = 32'h0; tg[2] = 32'h0; tg[3] = 32'h0;
        // which rst stall rv sel target clr | pc valid pend serr mis maddr
        // 1: reset, boot, sequential run
        step(0, 1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'h4,   1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'h8,   1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'hC,   1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'h10,  1, 0, 0, 0, 32'h0);
        // 2: unstalled redirect
        step(0, 0, 0, 1, 2, 32'h200, 0, 32'h200, 1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'h204, 1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 1, 0, 32'h20,  0, 32'h20,  1, 0, 0, 0, 32'h0);
        // 3: redirect buffered during stall, latest wins
        step(0, 0, 1, 1, 1, 32'h80,  0, 32'h20,  1, 1, 0, 0, 32'h0);
        step(0, 0, 1, 1, 3, 32'hC0,  0, 32'h20,  1, 1, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0,   0, 32'h20,  1, 1, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'hC0,  1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'hC4,  1, 0, 0, 0, 32'h0);
        step(0, 0, 1, 0, 0, 32'h0,   0, 32'hC4,  1, 0, 0, 0, 32'h0);
        // 4: misaligned target, ignored redirect, fault clear
        step(0, 0, 0, 1, 0, 32'h102, 0, 32'hC4,  0, 0, 0, 1, 32'h102);
        step(0, 0, 0, 1, 2, 32'h200, 0, 32'hC4,  0, 0, 0, 1, 32'h102);
        step(0, 0, 0, 0, 0, 32'h0,   1, 32'h100, 1, 0, 0, 0, 32'h102);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'h104, 1, 0, 0, 0, 32'h102);
        // 6: reset while a redirect is pending
        step(0, 0, 1, 1, 1, 32'h80,  0, 32'h104, 1, 1, 0, 0, 32'h102);
        step(0, 1, 1, 1, 1, 32'h80,  0, 32'h0,   0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0,   0, 32'h4,   1, 0, 0, 0, 32'h0);
        step(0, 1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0);
        // 5: NUM_SRC=3 instance, wrap and invalid select
        step(1, 1, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 0, 32'hFFFF_FFFC, 0, 32'hFFFF_FFFC, 1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0,   0, 32'h0,   1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 3, 32'h40,  0, 32'h4,   1, 0, 1, 0, 32'h0);
        step(1, 0, 0, 0, 0, 32'h0,   0, 32'h8,   1, 0, 0, 0, 32'h0);
        @(negedge clk);
        rv = 1'b0;
        @(posedge clk);
        #3;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d/%0d entries left, want 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
